// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes on both sides.
// One partial product per clock; the product is held in DONE until the consumer takes it.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [WIDTH-1:0]    acc_hi, acc_lo;
    logic [WIDTH:0]      add_res;
    logic [PROD_W-1:0]   acc_shift;

    // Partial-product add keeps the carry so hi+mcand never loses its MSB
    always_comb begin
        acc_hi    = acc_q[PROD_W-1:WIDTH];
        acc_lo    = acc_q[WIDTH-1:0];
        add_res   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand_q}) : {1'b0, acc_hi};
        acc_shift = {add_res, acc_lo[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    mcand_d = a;
                    acc_d   = {WIDTH'(0), b};
                    count_d = CNT_W'(0);
                end
            end
            RUN: begin
                acc_d   = acc_shift;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = acc_shift;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
